// File: rtl/lcd_pattern_gen_if.sv
// Pixel request/response bus between the RGB LCD timing controller (master)
// and a pixel source (slave).
interface lcd_pattern_gen_if;
    logic [11:0] lcd_xpos;
    logic [11:0] lcd_ypos;
    logic        lcd_vs;
    logic [23:0] lcd_data;

    modport master (output lcd_xpos, output lcd_ypos, output lcd_vs, input lcd_data);
    modport slave  (input lcd_xpos, input lcd_ypos, input lcd_vs, output lcd_data);
endinterface

// File: rtl/lcd_pattern_gen.sv
// Test-pattern pixel source: four selectable patterns, one-clock pixel latency,
// mode and scroll changes applied only at frame start so frames never tear.
module lcd_pattern_gen #(
    parameter int H_DISP      = 480,
    parameter int V_DISP      = 272,
    parameter int GRID_LOG2   = 5,
    parameter int SQ_LOG2     = 5,
    parameter int SCROLL_STEP = 2,
    parameter int DEB_CYCLES  = 180000
) (
    input  logic              clk,
    input  logic              rst,
    lcd_pattern_gen_if.slave  lcd,
    input  logic              key_n,
    output logic [1:0]        pattern_mode,
    output logic [7:0]        frame_cnt
);
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [11:0] STEP   = 12'(SCROLL_STEP);
    localparam logic [11:0] X_LAST = 12'(H_DISP - 1);
    localparam logic [11:0] Y_LAST = 12'(V_DISP - 1);
    localparam logic [11:0] BAR1 = 12'((1 * H_DISP) / 8);
    localparam logic [11:0] BAR2 = 12'((2 * H_DISP) / 8);
    localparam logic [11:0] BAR3 = 12'((3 * H_DISP) / 8);
    localparam logic [11:0] BAR4 = 12'((4 * H_DISP) / 8);
    localparam logic [11:0] BAR5 = 12'((5 * H_DISP) / 8);
    localparam logic [11:0] BAR6 = 12'((6 * H_DISP) / 8);
    localparam logic [11:0] BAR7 = 12'((7 * H_DISP) / 8);
    localparam logic [11:0] BAR8 = 12'(H_DISP);

    logic              vs_d_q;
    logic              key_sync1_q, key_sync2_q;
    logic              key_stable_q, key_stable_d;
    logic [CNT_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [1:0]        pending_q, pending_d;
    logic [1:0]        mode_q, mode_d;
    logic [7:0]        frame_q, frame_d;
    logic [11:0]       offset_q, offset_d;
    logic [23:0]       data_q, data_d;
    logic              fs;
    logic              press;
    logic [11:0]       xs;

    // Bar boundaries are constant compares, so no divider is needed.
    function automatic logic [23:0] bar_colour(input logic [11:0] x);
        if      (x < BAR1) return 24'hFFFFFF;
        else if (x < BAR2) return 24'hFFFF00;
        else if (x < BAR3) return 24'h00FFFF;
        else if (x < BAR4) return 24'h00FF00;
        else if (x < BAR5) return 24'hFF00FF;
        else if (x < BAR6) return 24'hFF0000;
        else if (x < BAR7) return 24'h0000FF;
        else if (x < BAR8) return 24'h000000;
        else               return 24'h000000;
    endfunction

    function automatic logic grid_hit(input logic [11:0] x, input logic [11:0] y);
        return (x[GRID_LOG2-1:0] == '0) || (y[GRID_LOG2-1:0] == '0) ||
               (x == X_LAST) || (y == Y_LAST);
    endfunction

    always_comb begin
        fs           = vs_d_q & ~lcd.lcd_vs;
        key_stable_d = key_stable_q;
        deb_cnt_d    = '0;
        if (key_sync2_q != key_stable_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                key_stable_d = key_sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
        press     = key_stable_q & ~key_stable_d;
        pending_d = pending_q + {1'b0, press};

        // Frame-start updates use the pending value from before any same-cycle press.
        mode_d   = mode_q;
        frame_d  = frame_q;
        offset_d = offset_q;
        if (fs) begin
            mode_d   = pending_q;
            frame_d  = frame_q + 8'd1;
            offset_d = offset_q + STEP;
        end
    end

    always_comb begin
        xs     = lcd.lcd_xpos + offset_q;
        data_d = 24'h000000;
        case (mode_q)
            2'd0: data_d = bar_colour(lcd.lcd_xpos);
            2'd1: data_d = grid_hit(lcd.lcd_xpos, lcd.lcd_ypos) ? 24'hFFFFFF : 24'h000000;
            2'd2: data_d = {lcd.lcd_ypos[7:0], lcd.lcd_xpos[8:1], frame_q};
            2'd3: data_d = (xs[SQ_LOG2] ^ lcd.lcd_ypos[SQ_LOG2]) ? 24'hFFFFFF : 24'h202020;
            default: data_d = 24'h000000;
        endcase
    end

    // Register stage: control state and the one-clock pixel output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d_q       <= 1'b1;
            key_sync1_q  <= 1'b1;
            key_sync2_q  <= 1'b1;
            key_stable_q <= 1'b1;
            deb_cnt_q    <= '0;
            pending_q    <= 2'd0;
            mode_q       <= 2'd0;
            frame_q      <= 8'd0;
            offset_q     <= 12'd0;
            data_q       <= 24'h000000;
        end else begin
            vs_d_q       <= lcd.lcd_vs;
            key_sync1_q  <= key_n;
            key_sync2_q  <= key_sync1_q;
            key_stable_q <= key_stable_d;
            deb_cnt_q    <= deb_cnt_d;
            pending_q    <= pending_d;
            mode_q       <= mode_d;
            frame_q      <= frame_d;
            offset_q     <= offset_d;
            data_q       <= data_d;
        end
    end

    assign lcd.lcd_data  = data_q;
    assign pattern_mode  = mode_q;
    assign frame_cnt     = frame_q;
endmodule
